mmio_timer_slave: RTL and testbench



---
 rtl/mmio_pkg.sv | 38 +++
 rtl/mmio_timer_slave_prescaler.sv | 35 +++
 rtl/mmio_timer_slave.sv | 123 ++++++++++++
 tb/tb_mmio_timer_slave.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the data-memory map and its timer slave:
// timer register offsets, CTRL bit positions and the CTRL register layout.
package mmio_pkg;

  localparam logic [31:0] TMR_BASE_ADDR = 32'h0000_0200;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_LOAD   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int TMR_PRESCALE_WIDTH = 8;
  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_AUTO_BIT      = 1;
  localparam int CTRL_IRQEN_BIT     = 2;
  localparam int CTRL_PSC_LSB       = 8;
  localparam int CTRL_PSC_MSB       = CTRL_PSC_LSB + TMR_PRESCALE_WIDTH - 1;
  localparam int STATUS_EXPIRED_BIT = 0;

  typedef struct packed {
    logic [TMR_PRESCALE_WIDTH-1:0] prescale;
    logic                          irqEn;
    logic                          autoReload;
    logic                          en;
  } tmr_ctrl_t;

  // Bus view of CTRL; unused bit positions read back as zero.
  function automatic logic [31:0] ctrlToWord(tmr_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]                = c.en;
    w[CTRL_AUTO_BIT]              = c.autoReload;
    w[CTRL_IRQEN_BIT]             = c.irqEn;
    w[CTRL_PSC_MSB:CTRL_PSC_LSB]  = c.prescale;
    return w;
  endfunction

endpackage

// File: rtl/mmio_timer_slave_prescaler.sv
// Prescaler for the MMIO timer: counts enabled cycles and emits a one-cycle
// tick each time the count matches the programmed prescale value.
module tmr_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_prescale,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_psc;
  logic             w_hit;

  assign w_hit  = (r_psc == i_prescale);
  assign o_tick = i_en && w_hit;

  // Clear takes priority so a freshly enabled timer always starts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc <= '0;
    end else if (i_clear) begin
      r_psc <= '0;
    end else if (i_en) begin
      if (w_hit) begin
        r_psc <= '0;
      end else begin
        r_psc <= r_psc + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_timer_slave.sv
// Memory-mapped prescaled down-counter: CTRL/LOAD/COUNT/STATUS registers,
// one-shot or auto-reload expiry, sticky W1C expiry flag and level interrupt.
module mmio_timer_slave
  import mmio_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  irq
);

  tmr_ctrl_t             r_ctrl;
  logic [DATA_WIDTH-1:0] r_load;
  logic [DATA_WIDTH-1:0] r_count;
  logic                  r_expired;

  logic [ADDR_WIDTH-1:0] w_addrField;
  logic [1:0]            w_offset;
  logic                  w_unusedAddr;
  logic                  w_wrCtrl;
  logic                  w_wrLoad;
  logic                  w_wrCount;
  logic                  w_wrStatus;
  logic                  w_pscClear;
  logic                  w_tick;
  logic                  w_expire;

  // Only the word offset inside the slave window selects a register.
  assign w_addrField  = address[ADDR_WIDTH-1:0];
  assign w_offset     = w_addrField[3:2];
  assign w_unusedAddr = ^{address[DATA_WIDTH-1:ADDR_WIDTH],
                          w_addrField[ADDR_WIDTH-1:4], w_addrField[1:0]};

  assign w_wrCtrl   = we && (w_offset == TMR_CTRL);
  assign w_wrLoad   = we && (w_offset == TMR_LOAD);
  assign w_wrCount  = we && (w_offset == TMR_COUNT);
  assign w_wrStatus = we && (w_offset == TMR_STATUS);

  assign w_pscClear = w_wrCtrl && wd[CTRL_EN_BIT] && !r_ctrl.en;
  assign w_expire   = w_tick && (r_count == '0);

  tmr_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_ctrl.en),
    .i_clear    (w_pscClear),
    .i_prescale (r_ctrl.prescale),
    .o_tick     (w_tick)
  );

  // A bus write to CTRL overrides the one-shot auto-disable in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
    end else if (w_wrCtrl) begin
      r_ctrl <= '{prescale:   wd[CTRL_PSC_MSB:CTRL_PSC_LSB],
                  irqEn:      wd[CTRL_IRQEN_BIT],
                  autoReload: wd[CTRL_AUTO_BIT],
                  en:         wd[CTRL_EN_BIT]};
    end else if (w_expire && !r_ctrl.autoReload) begin
      r_ctrl.en <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load <= '0;
    end else if (w_wrLoad) begin
      r_load <= wd;
    end
  end

  // Bus writes beat the tick; a one-shot expiry simply leaves COUNT at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wrCount) begin
      r_count <= wd;
    end else if (w_tick) begin
      if (r_count != '0) begin
        r_count <= r_count - DATA_WIDTH'(1);
      end else if (r_ctrl.autoReload) begin
        r_count <= r_load;
      end
    end
  end

  // Expiry has priority over write-1-to-clear so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expired <= 1'b0;
    end else if (w_expire) begin
      r_expired <= 1'b1;
    end else if (w_wrStatus && wd[STATUS_EXPIRED_BIT]) begin
      r_expired <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    if (re) begin
      unique case (w_offset)
        TMR_CTRL:   rd = DATA_WIDTH'(ctrlToWord(r_ctrl));
        TMR_LOAD:   rd = r_load;
        TMR_COUNT:  rd = r_count;
        TMR_STATUS: rd = DATA_WIDTH'(r_expired);
      endcase
    end
  end

  assign irq = r_expired && r_ctrl.irqEn;

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Self-checking bench for mmio_timer_slave: directed scenarios plus a
// randomized run compared against a cycle-level behavioural timer model.
module tb_mmio_timer_slave;
  import mmio_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] wd;
  logic [31:0] address;
  logic        we;
  logic        re;
  logic [31:0] rd;
  logic        irq;

  int passCount  = 0;
  int checkCount = 0;

  // Behavioural model state
  logic        mEn, mAuto, mIrqEn, mExpired;
  logic [7:0]  mPre, mPsc;
  logic [31:0] mLoad, mCount;

  mmio_timer_slave #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (7),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wd      (wd),
    .address (address),
    .we      (we),
    .re      (re),
    .rd      (rd),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] regAddr(logic [1:0] off);
    return {28'h0, off, 2'b00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] off, input logic [31:0] data);
    address = regAddr(off);
    wd      = data;
    we      = 1'b1;
    @(posedge clk);
    #1;
    we      = 1'b0;
    wd      = '0;
  endtask

  task automatic busRead(input logic [1:0] off, output logic [31:0] data);
    address = regAddr(off);
    re      = 1'b1;
    #1;
    data    = rd;
    re      = 1'b0;
  endtask

  task automatic modelReset();
    mEn = 0; mAuto = 0; mIrqEn = 0; mExpired = 0;
    mPre = 0; mPsc = 0; mLoad = 0; mCount = 0;
  endtask

  function automatic logic [31:0] modelRead(logic [1:0] off);
    case (off)
      TMR_CTRL:  return {16'h0, mPre, 5'h0, mIrqEn, mAuto, mEn};
      TMR_LOAD:  return mLoad;
      TMR_COUNT: return mCount;
      default:   return {31'h0, mExpired};
    endcase
  endfunction

  // One clock of timer behaviour; later assignments express which event wins.
  task automatic modelStep(input logic doWrite, input logic [1:0] off, input logic [31:0] data);
    logic tickNow, expireNow;
    tickNow   = mEn && (mPsc == mPre);
    expireNow = tickNow && (mCount == 0);
    if (doWrite && off == TMR_CTRL && data[0] && !mEn) mPsc = 0;
    else if (mEn) mPsc = tickNow ? 8'd0 : mPsc + 8'd1;
    if (tickNow) begin
      if (mCount != 0) mCount = mCount - 1;
      else if (mAuto) mCount = mLoad;
    end
    if (expireNow && !mAuto) mEn = 0;
    if (doWrite && off == TMR_STATUS && data[0]) mExpired = 0;
    if (expireNow) mExpired = 1;
    if (doWrite && off == TMR_COUNT) mCount = data;
    if (doWrite && off == TMR_LOAD) mLoad = data;
    if (doWrite && off == TMR_CTRL) begin
      mEn = data[0]; mAuto = data[1]; mIrqEn = data[2]; mPre = data[15:8];
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    busWrite(TMR_CTRL, 32'h1);
    tick();
    busRead(TMR_STATUS, v);
    checkCount++;
    if (v !== 32'h1) $display("FAIL reset_pre_expired got=%0h exp=%0h", v, 32'h1); else passCount++;
    busWrite(TMR_LOAD, 32'h7);
    busWrite(TMR_COUNT, 32'h5);
    busWrite(TMR_CTRL, 32'h305);
    tick();
    tick();
    checkCount++;
    if (irq !== 1'b1) $display("FAIL reset_pre_irq got=%0b exp=1", irq); else passCount++;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      busRead(2'(i), v);
      checkCount++;
      if (v !== 32'h0) $display("FAIL reset_reg%0d got=%0h exp=0", i, v); else passCount++;
    end
    checkCount++;
    if (irq !== 1'b0) $display("FAIL reset_irq got=%0b exp=0", irq); else passCount++;
    tick();
    rst = 1'b0;
    tick();
    busRead(TMR_CTRL, v);
    checkCount++;
    if (v !== 32'h0) $display("FAIL reset_ctrl_after got=%0h exp=0", v); else passCount++;
  endtask

  task automatic test_one_shot();
    logic [31:0] v;
    logic [31:0] expCount [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
    busWrite(TMR_COUNT, 32'd3);
    busWrite(TMR_CTRL, 32'h5);
    for (int i = 0; i < 4; i++) begin
      busRead(TMR_COUNT, v);
      checkCount++;
      if (v !== expCount[i]) $display("FAIL oneshot_count%0d got=%0h exp=%0h", i, v, expCount[i]); else passCount++;
      busRead(TMR_STATUS, v);
      checkCount++;
      if (v !== 32'h0) $display("FAIL oneshot_early_expired%0d got=%0h exp=0", i, v); else passCount++;
      tick();
    end
    busRead(TMR_STATUS, v);
    checkCount++;
    if (v !== 32'h1) $display("FAIL oneshot_expired got=%0h exp=1", v); else passCount++;
    checkCount++;
    if (irq !== 1'b1) $display("FAIL oneshot_irq got=%0b exp=1", irq); else passCount++;
    busRead(TMR_CTRL, v);
    checkCount++;
    if (v !== 32'h4) $display("FAIL oneshot_ctrl got=%0h exp=4", v); else passCount++;
    tick();
    tick();
    busRead(TMR_COUNT, v);
    checkCount++;
    if (v !== 32'h0) $display("FAIL oneshot_count_hold got=%0h exp=0", v); else passCount++;
  endtask

  task automatic test_auto_reload();
    logic [31:0] v;
    int cyc   = 0;
    int found = 0;
    busWrite(TMR_STATUS, 32'h1);
    busWrite(TMR_LOAD, 32'd2);
    busWrite(TMR_COUNT, 32'd2);
    busWrite(TMR_CTRL, 32'h303);
    while (found < 3 && cyc <= 40) begin
      busRead(TMR_STATUS, v);
      if (v[0]) begin
        found++;
        checkCount++;
        if (cyc !== 12 * found) $display("FAIL auto_period%0d got=%0d exp=%0d", found, cyc, 12 * found); else passCount++;
        busRead(TMR_COUNT, v);
        checkCount++;
        if (v !== 32'd2) $display("FAIL auto_reload%0d got=%0h exp=2", found, v); else passCount++;
        busWrite(TMR_STATUS, 32'h1);
      end else begin
        tick();
      end
      cyc++;
    end
    checkCount++;
    if (found !== 3) $display("FAIL auto_expiry_count got=%0d exp=3", found); else passCount++;
    busWrite(TMR_CTRL, 32'h0);
    busWrite(TMR_STATUS, 32'h1);
  endtask

  task automatic test_w1c_race();
    logic [31:0] v;
    busWrite(TMR_COUNT, 32'd1);
    busWrite(TMR_CTRL, 32'h5);
    tick();
    busRead(TMR_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("FAIL w1c_pre got=%0h exp=0", v); else passCount++;
    busWrite(TMR_STATUS, 32'h1);
    busRead(TMR_STATUS, v);
    checkCount++;
    if (v !== 32'h1) $display("FAIL w1c_race_set got=%0h exp=1", v); else passCount++;
    busWrite(TMR_STATUS, 32'h0);
    busRead(TMR_STATUS, v);
    checkCount++;
    if (v !== 32'h1) $display("FAIL w1c_zero_write got=%0h exp=1", v); else passCount++;
    busWrite(TMR_STATUS, 32'h1);
    busRead(TMR_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("FAIL w1c_clear got=%0h exp=0", v); else passCount++;
    checkCount++;
    if (irq !== 1'b0) $display("FAIL w1c_irq got=%0b exp=0", irq); else passCount++;
  endtask

  task automatic test_write_tick_collision();
    logic [31:0] v;
    busWrite(TMR_COUNT, 32'h1000);
    busWrite(TMR_CTRL, 32'h1);
    tick();
    tick();
    busRead(TMR_COUNT, v);
    checkCount++;
    if (v !== 32'hFFE) $display("FAIL collide_pre got=%0h exp=ffe", v); else passCount++;
    busWrite(TMR_COUNT, 32'h100);
    busRead(TMR_COUNT, v);
    checkCount++;
    if (v !== 32'h100) $display("FAIL collide_write got=%0h exp=100", v); else passCount++;
    tick();
    busRead(TMR_COUNT, v);
    checkCount++;
    if (v !== 32'hFF) $display("FAIL collide_next got=%0h exp=ff", v); else passCount++;
    busWrite(TMR_CTRL, 32'h0);
  endtask

  task automatic test_read_gating();
    busWrite(TMR_COUNT, 32'h5A5A);
    busWrite(TMR_LOAD, 32'h1234_5678);
    address = 32'h8;
    re      = 1'b0;
    #1;
    checkCount++;
    if (rd !== 32'h0) $display("FAIL gate_re0 got=%0h exp=0", rd); else passCount++;
    re = 1'b1;
    #1;
    checkCount++;
    if (rd !== 32'h5A5A) $display("FAIL gate_count got=%0h exp=5a5a", rd); else passCount++;
    address = 32'hFFFF_FF04;
    #1;
    checkCount++;
    if (rd !== 32'h1234_5678) $display("FAIL gate_load_hi got=%0h exp=12345678", rd); else passCount++;
    address = 32'h34;
    #1;
    checkCount++;
    if (rd !== 32'h1234_5678) $display("FAIL gate_load_mid got=%0h exp=12345678", rd); else passCount++;
    re = 1'b0;
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 400; i++) begin
      logic        doWrite, doRead;
      logic [1:0]  off;
      logic [31:0] data, expRd;
      doWrite = ($urandom_range(0, 3) == 0);
      doRead  = ($urandom_range(0, 3) != 0);
      off     = 2'($urandom_range(0, 3));
      data    = $urandom;
      if (off == TMR_CTRL) begin
        data[15:8] = 8'($urandom_range(0, 3));
        data[0]    = ($urandom_range(0, 3) != 0);
      end else if (off != TMR_STATUS && $urandom_range(0, 7) != 0) begin
        data = 32'($urandom_range(0, 6));
      end
      address      = $urandom;
      address[3:2] = off;
      wd = data;
      we = doWrite;
      re = doRead;
      #1;
      expRd = doRead ? modelRead(off) : 32'h0;
      checkCount++;
      if (rd !== expRd) $display("FAIL rand_rd step=%0d off=%0d got=%0h exp=%0h", i, off, rd, expRd); else passCount++;
      checkCount++;
      if (irq !== (mExpired && mIrqEn)) $display("FAIL rand_irq step=%0d got=%0b exp=%0b", i, irq, mExpired && mIrqEn); else passCount++;
      @(posedge clk);
      modelStep(doWrite, off, data);
      #1;
    end
    we = 1'b0;
    re = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    we      = 1'b0;
    re      = 1'b0;
    wd      = '0;
    address = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_w1c_race();
    test_write_tick_collision();
    test_read_gating();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
